modmul_pipe: RTL and testbench
==============================

// Module: modmul_pipe
// PURPOSE
//   Pipelined modular multiplier s = (a*b) mod Q for Fermat-form moduli Q = 2^K + 1, K = LOGQ-1.
//   Multiplies, then reduces with the 2^K == -1 identity: p = H*2^K + L gives p == L - H,
//   followed by one conditional +Q. Replaces the combinational reducer on the NTT butterfly
//   twiddle-multiply path. Fully streaming with valid/ready on both sides; accepts one product per cycle.
// PARAMETERS
//   LOGQ   17  operand/result width; Q = 2^(LOGQ-1)+1 (17 -> 65537, 9 -> 257); legal range 3..32
//   TAGW   4   width of sideband tag carried with each operand pair (only with MODMUL_TAG_EN)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand pair presented
//   in_ready   out  1        block accepts the pair this cycle
//   in_a       in   LOGQ     operand a, 0..Q-1
//   in_b       in   LOGQ     operand b, 0..Q-1
//   in_tag     in   TAGW     sideband tag (port exists only with MODMUL_TAG_EN)
//   out_valid  out  1        result presented
//   out_ready  in   1        downstream accepts the result
//   out_s      out  LOGQ     (in_a*in_b) mod Q, 0..Q-1
//   out_tag    out  TAGW     tag of the pair that produced out_s (only with MODMUL_TAG_EN)
// BEHAVIOUR
//   - Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
//   - Three register stages:
//       S1 latches a, b
//       S2 latches p = a*b (2*LOGQ bits)
//       S3 latches the reduced value
//     Each stage has a valid bit v1..v3.
//   - Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
//     out_valid = v3; out_s/out_tag come straight from S3 registers.
//   - Stage advance (bubble-collapsing):
//       ld3 = ~v3 | out_ready
//       ld2 = ~v2 | ld3
//       ld1 = ~v1 | ld2
//       in_ready = ld1 (combinational from out_ready and v1..v3; no path from in_valid)
//   - Loading a stage copies the upstream valid bit; a bubble propagates as valid=0.
//     Data registers update only when the upstream valid is 1.
//   - Latency: 3 cycles from accepted input to out_valid when unstalled.
//     Throughput: 1 result/cycle. Results leave strictly in input order; none dropped or duplicated.
//   - Stall: while out_ready=0 the S3 contents and out_valid hold stable. Upstream stages fill,
//     then in_ready falls. At most 3 results are held in flight.
//   - Reduction (S2 -> S3), with K = LOGQ-1:
//       L = p[K-1:0], H = p[2K:K] (K+1 bits)
//       d = L - H in (K+2)-bit signed
//       result = d < 0 ? d + Q : d
//     One correction always suffices because operands are <= 2^K. Result range is 0..2^K.
//   - Operands >= Q: output undefined but handshake/order behaviour unaffected.
//     No flag is raised; the caller guarantees range.
//   - Reset, including mid-operation: v1..v3 = 0, out_valid = 0, out_s = 0, out_tag = 0,
//     in_ready = 1 on the first cycle after release. In-flight pairs are discarded.
//   - Simultaneous full pipeline with out_ready=1 and in_valid=1: output and input both transfer
//     that cycle and every stage shifts.
// CONFIGURATION
//   MODMUL_TAG_EN defined:
//     in_tag/out_tag ports exist; the tag rides S1..S3 beside the data under the same load enables.
//     out_tag is reset to 0.
//   MODMUL_TAG_EN undefined:
//     no tag ports or registers; all other behaviour identical.
// TESTING
//   LOGQ=17:
//     a=3, b=5 -> out_s=15 exactly 3 cycles after acceptance.
//     a=65536, b=65536 -> 1.
//     a=65536, b=2 -> 65535.
//     a=0, b=40000 -> 0.
//   LOGQ=9:
//     a=256, b=256 -> 1.
//     a=200, b=100 -> 211.
//     a=128, b=2 -> 256 (range top).
//   Backpressure:
//     out_ready=0 for 6 cycles, in_valid=1 with pairs (1,1),(1,2),(1,3),(1,4).
//     Exactly 3 accepted, then in_ready=0. out_s holds 1 and is stable throughout.
//     After out_ready=1: 1,2,3,4 in order, no gaps once full.
//   Bubbles:
//     in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid pattern identical, delayed 3 cycles.
//     With out_ready=0, the two items compact into adjacent stages.
//   Reset mid-stream:
//     rst_n low asynchronously (off clock edge) with 3 items in flight.
//     out_valid=0, out_s=0 immediately. After release, in_ready=1 and no stale result ever appears.
//   Random stream:
//     10k random operand pairs in 0..Q-1 with random out_ready, LOGQ in {9,17}, MODMUL_TAG_EN
//     on and off. Every out_s equals the a*b%Q reference; out_tag matches in order.

Source files
------------

// File: rtl/modmul_pipe.sv
// Pipelined Fermat-modulus multiplier s = a*b mod (2^(LOGQ-1)+1). MODMUL_TAG_EN adds an in_tag/out_tag sideband.
// Latency is 3 cycles and throughput is one result per cycle.
// Backpressure: stages collapse bubbles, and in_ready falls only when S1..S3 are full and out_ready is low.
module modmul_pipe #(
  parameter int LOGQ = 17
`ifdef MODMUL_TAG_EN
  ,
  parameter int TAGW = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] in_a,
  input  logic [LOGQ-1:0] in_b,
`ifdef MODMUL_TAG_EN
  input  logic [TAGW-1:0] in_tag,
  output logic [TAGW-1:0] out_tag,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_s
);

  localparam int K = LOGQ - 1;
  localparam logic [LOGQ-1:0] Q = {1'b1, {(K-1){1'b0}}, 1'b1};

  logic              v1, v2, v3;
  logic              ld1, ld2, ld3;
  logic [LOGQ-1:0]   a1, b1;
  logic [2*LOGQ-1:0] p2;
  logic [LOGQ-1:0]   s3;

  logic [2*LOGQ-1:0] prod;
  logic [K-1:0]      lo;
  logic [K:0]        hi;
  logic [K+1:0]      d;
  logic [LOGQ-1:0]   red;
  logic              p2_top_unused;

  assign ld3      = ~v3 | out_ready;
  assign ld2      = ~v2 | ld3;
  assign ld1      = ~v1 | ld2;
  assign in_ready = ld1;

  assign out_valid = v3;
  assign out_s     = s3;

  assign prod = {{LOGQ{1'b0}}, a1} * {{LOGQ{1'b0}}, b1};

  // 2^K == -1 (mod Q): p = H*2^K + L reduces to L - H, then at most one +Q.
  assign lo  = p2[K-1:0];
  assign hi  = p2[2*K:K];
  assign d   = {2'b00, lo} - {1'b0, hi};
  assign red = d[K+1] ? (d[K:0] + Q) : d[K:0];

  // The top product bit is nonzero only for out-of-range operands.
  assign p2_top_unused = p2[2*LOGQ-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      p2 <= '0;
      s3 <= '0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1 <= in_a;
          b1 <= in_b;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) p2 <= prod;
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) s3 <= red;
      end
    end
  end

`ifdef MODMUL_TAG_EN
  logic [TAGW-1:0] t1, t2, t3;

  assign out_tag = t3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
    end else begin
      if (ld1 && in_valid) t1 <= in_tag;
      if (ld2 && v1)       t2 <= t1;
      if (ld3 && v2)       t3 <= t2;
    end
  end
`endif

endmodule

// File: tb/tb_modmul_pipe.sv
// Scoreboard bench for modmul_pipe at LOGQ=17 and LOGQ=9. Build with MODMUL_TAG_EN defined to cover the tag sideband.
module tb_modmul_pipe;

  localparam longint Q17 = 65537;
  localparam longint Q9  = 257;

  typedef struct packed { logic [16:0] s; logic [3:0] tag; } e17_t;
  typedef struct packed { logic [8:0]  s; logic [3:0] tag; } e9_t;

  logic clk = 1'b0;
  logic rst_n;
  logic iv, ir, ov, ordy;
  logic [16:0] ia, ib, os;
  logic iv9, ir9, ov9, ordy9;
  logic [8:0] ia9, ib9, os9;
`ifdef MODMUL_TAG_EN
  logic [3:0] itag, otag, itag9, otag9;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  e17_t q17[$];
  e9_t  q9[$];

  always #5 clk = ~clk;

  modmul_pipe #(.LOGQ(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib),
`ifdef MODMUL_TAG_EN
    .in_tag(itag), .out_tag(otag),
`endif
    .out_valid(ov), .out_ready(ordy), .out_s(os));

  modmul_pipe #(.LOGQ(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv9), .in_ready(ir9), .in_a(ia9), .in_b(ib9),
`ifdef MODMUL_TAG_EN
    .in_tag(itag9), .out_tag(otag9),
`endif
    .out_valid(ov9), .out_ready(ordy9), .out_s(os9));

  function automatic logic [16:0] ref17(input logic [16:0] a, input logic [16:0] b);
    return 17'((longint'(a) * longint'(b)) % Q17);
  endfunction

  function automatic logic [8:0] ref9(input logic [8:0] a, input logic [8:0] b);
    return 9'((longint'(a) * longint'(b)) % Q9);
  endfunction

  task automatic push17(input logic [16:0] s);
    e17_t e;
    e.s = s;
    e.tag = '0;
`ifdef MODMUL_TAG_EN
    e.tag = itag;
`endif
    q17.push_back(e);
  endtask

  task automatic push9(input logic [8:0] s);
    e9_t e;
    e.s = s;
    e.tag = '0;
`ifdef MODMUL_TAG_EN
    e.tag = itag9;
`endif
    q9.push_back(e);
  endtask

  // Output monitors: a transfer happens at the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    e17_t e;
    logic tag_ok;
    if (rst_n === 1'b1 && ov === 1'b1 && ordy === 1'b1) begin
      n_checks++;
      if (q17.size() == 0) begin
        $display("FAIL sb17_extra: out_s=%0d appeared with no result outstanding", os);
      end else begin
        e = q17.pop_front();
        tag_ok = 1'b1;
`ifdef MODMUL_TAG_EN
        tag_ok = (otag === e.tag);
`endif
        if (os !== e.s || !tag_ok)
          $display("FAIL sb17_result: out_s=%0d tag_ok=%0b, required out_s=%0d", os, tag_ok, e.s);
        else
          n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    e9_t e;
    logic tag_ok;
    if (rst_n === 1'b1 && ov9 === 1'b1 && ordy9 === 1'b1) begin
      n_checks++;
      if (q9.size() == 0) begin
        $display("FAIL sb9_extra: out_s=%0d appeared with no result outstanding", os9);
      end else begin
        e = q9.pop_front();
        tag_ok = 1'b1;
`ifdef MODMUL_TAG_EN
        tag_ok = (otag9 === e.tag);
`endif
        if (os9 !== e.s || !tag_ok)
          $display("FAIL sb9_result: out_s=%0d tag_ok=%0b, required out_s=%0d", os9, tag_ok, e.s);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic drive17(input logic [16:0] a, input logic [16:0] b, input logic [16:0] s);
    int w = 0;
    ia = a; ib = b; iv = 1'b1;
`ifdef MODMUL_TAG_EN
    itag = 4'($urandom);
`endif
    @(negedge clk);
    while (ir !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (ir !== 1'b1) begin
      n_checks++;
      $display("FAIL drive17_timeout: in_ready=%b after %0d cycles, required 1", ir, w);
    end else begin
      push17(s);
    end
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic drive9(input logic [8:0] a, input logic [8:0] b, input logic [8:0] s);
    int w = 0;
    ia9 = a; ib9 = b; iv9 = 1'b1;
`ifdef MODMUL_TAG_EN
    itag9 = 4'($urandom);
`endif
    @(negedge clk);
    while (ir9 !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (ir9 !== 1'b1) begin
      n_checks++;
      $display("FAIL drive9_timeout: in_ready=%b after %0d cycles, required 1", ir9, w);
    end else begin
      push9(s);
    end
    @(posedge clk); #1;
    iv9 = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    ordy = 1'b1; ordy9 = 1'b1;
    while ((q17.size() != 0 || q9.size() != 0 || ov === 1'b1 || ov9 === 1'b1) && w < 300) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 300) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d/%0d results still outstanding, required 0/0", q17.size(), q9.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0;
    iv9 = 1'b0; ordy9 = 1'b0; ia9 = '0; ib9 = '0;
`ifdef MODMUL_TAG_EN
    itag = '0; itag9 = '0;
`endif
    #2;
    n_checks++;
    if (ov !== 1'b0 || os !== 17'd0 || ov9 !== 1'b0 || os9 !== 9'd0)
      $display("FAIL reset_outputs: out_valid=%b/%b out_s=%0d/%0d, required 0", ov, ov9, os, os9);
    else n_pass++;
    n_checks++;
    if (ir !== 1'b1 || ir9 !== 1'b1)
      $display("FAIL reset_in_ready: in_ready=%b/%b, required 1", ir, ir9);
    else n_pass++;
`ifdef MODMUL_TAG_EN
    n_checks++;
    if (otag !== 4'd0 || otag9 !== 4'd0)
      $display("FAIL reset_tag: out_tag=%0d/%0d, required 0", otag, otag9);
    else n_pass++;
`endif
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 and 0", ir, ov);
    else n_pass++;
  endtask

  task automatic test_latency();
    int cycles = 1;
    ordy = 1'b1;
    drive17(17'd3, 17'd5, 17'd15);
    while (ov !== 1'b1 && cycles < 10) begin @(posedge clk); #1; cycles++; end
    n_checks++;
    if (cycles != 3) $display("FAIL latency: out_valid after %0d cycles, required 3", cycles);
    else n_pass++;
    n_checks++;
    if (os !== 17'd15) $display("FAIL latency_value: out_s=%0d, required 15", os);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_vectors17();
    ordy = 1'b1;
    drive17(17'd65536, 17'd65536, 17'd1);
    drive17(17'd65536, 17'd2,     17'd65535);
    drive17(17'd0,     17'd40000, 17'd0);
    drive17(17'd65536, 17'd1,     17'd65536);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    ordy = 1'b0; ia = 17'd1; ib = 17'd1; iv = 1'b1;
`ifdef MODMUL_TAG_EN
    itag = 4'd1;
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov === 1'b1) begin
        n_checks++;
        if (os !== 17'd1) $display("FAIL bp_hold: cycle %0d out_s=%0d, required 1", c, os);
        else n_pass++;
      end
      if (ir === 1'b1 && acc < 4) begin
        push17(ib);
        acc++;
`ifdef MODMUL_TAG_EN
        itag = 4'(acc + 1);
`endif
      end
      @(posedge clk); #1;
      if (acc < 4) ib = 17'(acc + 1);
    end
    n_checks++;
    if (acc != 3 || ir !== 1'b0)
      $display("FAIL bp_fill: accepted=%0d in_ready=%b, required 3 and 0", acc, ir);
    else n_pass++;
    n_checks++;
    if (ov !== 1'b1 || os !== 17'd1)
      $display("FAIL bp_stall_out: out_valid=%b out_s=%0d, required 1 and 1", ov, os);
    else n_pass++;
    ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov !== 1'b1) $display("FAIL bp_nogap: release cycle %0d out_valid=%b, required 1", c, ov);
      else n_pass++;
      if (iv === 1'b1 && ir === 1'b1) begin push17(ib); acc++; end
      @(posedge clk); #1;
      if (acc == 4) iv = 1'b0;
    end
    n_checks++;
    if (acc != 4) $display("FAIL bp_accept4: accepted=%0d, required 4", acc);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_bubbles();
    logic inh [8];
    logic ovh [8];
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      iv = (c < 4) && (c % 2 == 0);
      ia = 17'(c + 7); ib = 17'(c * 1000 + 100);
`ifdef MODMUL_TAG_EN
      itag = 4'(c);
`endif
      @(negedge clk);
      inh[c] = iv;
      ovh[c] = ov;
      if (iv === 1'b1 && ir === 1'b1) push17(ref17(ia, ib));
      @(posedge clk); #1;
    end
    iv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ovh[c+3] !== inh[c])
        $display("FAIL bubble_pattern: out_valid[%0d]=%b, required %b", c + 3, ovh[c+3], inh[c]);
      else n_pass++;
    end
    wait_drain();

    ordy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      iv = (c == 0 || c == 2);
      ia = 17'(c + 20); ib = 17'(c + 30000);
`ifdef MODMUL_TAG_EN
      itag = 4'(c + 8);
`endif
      @(negedge clk);
      if (iv === 1'b1 && ir === 1'b1) push17(ref17(ia, ib));
      @(posedge clk); #1;
    end
    iv = 1'b0;
    n_checks++;
    if (ov !== 1'b1 || ir !== 1'b1)
      $display("FAIL bubble_compact: out_valid=%b in_ready=%b, required 1 and 1", ov, ir);
    else n_pass++;
    ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov !== (c < 2)) $display("FAIL bubble_adjacent: cycle %0d out_valid=%b, required %b", c, ov, c < 2);
      else n_pass++;
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    ordy = 1'b0;
    drive17(17'd11, 17'd12, 17'd132);
    drive17(17'd13, 17'd14, 17'd182);
    drive17(17'd15, 17'd16, 17'd240);
    n_checks++;
    if (ov !== 1'b1) $display("FAIL midrst_prefill: out_valid=%b, required 1", ov);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov !== 1'b0 || os !== 17'd0)
      $display("FAIL midrst_async: out_valid=%b out_s=%0d, required 0 and 0", ov, os);
    else n_pass++;
`ifdef MODMUL_TAG_EN
    n_checks++;
    if (otag !== 4'd0) $display("FAIL midrst_tag: out_tag=%0d, required 0", otag);
    else n_pass++;
`endif
    q17.delete();
    q9.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ir !== 1'b1) $display("FAIL midrst_in_ready: in_ready=%b, required 1", ir);
    else n_pass++;
    ordy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov !== 1'b0) $display("FAIL midrst_stale: cycle %0d out_valid=%b out_s=%0d, required 0", c, ov, os);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_vectors9();
    ordy9 = 1'b1;
    drive9(9'd256, 9'd256, 9'd1);
    drive9(9'd200, 9'd100, 9'd211);
    drive9(9'd128, 9'd2,   9'd256);
    drive9(9'd0,   9'd77,  9'd0);
    wait_drain();
  endtask

  task automatic test_random17(input int n);
    int sent = 0;
    int cyc = 0;
    logic took;
    iv = 1'b0;
    while (sent < n && cyc < 40000) begin
      ordy = ($urandom_range(3) != 0);
      if (iv !== 1'b1 && $urandom_range(3) != 0) begin
        ia = ($urandom_range(15) == 0) ? 17'd65536 : 17'($urandom_range(65536));
        ib = ($urandom_range(15) == 0) ? 17'd65536 : 17'($urandom_range(65536));
`ifdef MODMUL_TAG_EN
        itag = 4'($urandom);
`endif
        iv = 1'b1;
      end
      @(negedge clk);
      took = (iv === 1'b1 && ir === 1'b1);
      if (took) begin push17(ref17(ia, ib)); sent++; end
      @(posedge clk); #1;
      if (took) iv = 1'b0;
      cyc++;
    end
    iv = 1'b0;
    if (sent < n) begin
      n_checks++;
      $display("FAIL random17_budget: sent %0d, required %0d", sent, n);
    end
    wait_drain();
  endtask

  task automatic test_random9(input int n);
    int sent = 0;
    int cyc = 0;
    logic took;
    iv9 = 1'b0;
    while (sent < n && cyc < 40000) begin
      ordy9 = ($urandom_range(3) != 0);
      if (iv9 !== 1'b1 && $urandom_range(3) != 0) begin
        ia9 = 9'($urandom_range(256));
        ib9 = 9'($urandom_range(256));
`ifdef MODMUL_TAG_EN
        itag9 = 4'($urandom);
`endif
        iv9 = 1'b1;
      end
      @(negedge clk);
      took = (iv9 === 1'b1 && ir9 === 1'b1);
      if (took) begin push9(ref9(ia9, ib9)); sent++; end
      @(posedge clk); #1;
      if (took) iv9 = 1'b0;
      cyc++;
    end
    iv9 = 1'b0;
    if (sent < n) begin
      n_checks++;
      $display("FAIL random9_budget: sent %0d, required %0d", sent, n);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors17();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    test_vectors9();
    test_random17(5000);
    test_random9(5000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
